// File: rtl/wb_select_stage.sv
// MEM/WB pipeline stage: picks the writeback source, formats loads and counts retired writes.
// Define WB_LOAD_SUBWORD_EN to enable byte/half loads, extension and the misalignment check.
module wb_select_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [1:0]        in_wb_sel,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_read_data,
   input  logic [DATA_W-1:0] in_link,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [1:0]        in_mem_size,
   input  logic              in_mem_unsigned,
   input  logic [1:0]        in_byte_off,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_misalign,
   output logic [CNT_W-1:0]  retire_count
);

   logic [DATA_W-1:0] mem_data;
   logic              misaligned;
   logic [DATA_W-1:0] sel_data;
   logic              mis_now;
   logic              we_now;

`ifdef WB_LOAD_SUBWORD_EN
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        fill;

   // Fill the whole word with the extension bit first, then overlay the loaded lane.
   always_comb begin
      case (in_byte_off)
         2'd0:    byte_lane = in_read_data[7:0];
         2'd1:    byte_lane = in_read_data[15:8];
         2'd2:    byte_lane = in_read_data[23:16];
         default: byte_lane = in_read_data[31:24];
      endcase
      half_lane  = in_byte_off[1] ? in_read_data[31:16] : in_read_data[15:0];
      fill       = 1'b0;
      misaligned = 1'b0;
      mem_data   = '0;
      case (in_mem_size)
         2'b00: begin
            fill          = ~in_mem_unsigned & byte_lane[7];
            mem_data      = {DATA_W{fill}};
            mem_data[7:0] = byte_lane;
         end
         2'b01: begin
            fill           = ~in_mem_unsigned & half_lane[15];
            mem_data       = {DATA_W{fill}};
            mem_data[15:0] = half_lane;
            misaligned     = in_byte_off[0];
         end
         default: begin
            fill           = ~in_mem_unsigned & in_read_data[31];
            mem_data       = {DATA_W{fill}};
            mem_data[31:0] = in_read_data[31:0];
            misaligned     = (in_byte_off != 2'b00);
         end
      endcase
   end
`else
   logic unused_load_cfg;

   assign unused_load_cfg = ^{in_mem_size, in_mem_unsigned, in_byte_off};
   assign mem_data        = in_read_data;
   assign misaligned      = 1'b0;
`endif

   always_comb begin
      case (in_wb_sel)
         2'b00:   sel_data = in_alu_result;
         2'b01:   sel_data = mem_data;
         2'b10:   sel_data = in_link;
         default: sel_data = in_imm;
      endcase
   end

   assign mis_now = in_valid & (in_wb_sel == 2'b01) & misaligned;
   assign we_now  = in_valid & in_reg_write & (in_rd != '0) & ~mis_now;

   // Flush turns the stage into a bubble but leaves rd/data untouched; stall freezes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_we        <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_misalign  <= 1'b0;
         retire_count <= '0;
      end else if (flush) begin
         wb_valid    <= 1'b0;
         wb_we       <= 1'b0;
         wb_misalign <= 1'b0;
      end else if (!stall) begin
         wb_valid    <= in_valid;
         wb_we       <= we_now;
         wb_rd       <= in_rd;
         wb_data     <= sel_data;
         wb_misalign <= mis_now;
         if (we_now) begin
            retire_count <= retire_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: spec-level model with per-cycle compare plus literal pins.
module tb_wb_select_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        in_valid, in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [31:0] in_alu_result, in_read_data, in_link, in_imm;
   logic [1:0]  in_mem_size;
   logic        in_mem_unsigned;
   logic [1:0]  in_byte_off;

   logic        wb_valid, wb_we, wb_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] retire_count;

   logic        s_valid, s_we, s_misalign;
   logic [4:0]  s_rd;
   logic [31:0] s_data;
   logic [3:0]  s_count;

   int checks = 0;
   int errors = 0;

`ifdef WB_LOAD_SUBWORD_EN
   localparam int MIS_EXTRA = 0;
`else
   localparam int MIS_EXTRA = 1;
`endif

   always #5 clk = ~clk;

   wb_select_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
      .in_read_data(in_read_data), .in_link(in_link), .in_imm(in_imm),
      .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
      .in_byte_off(in_byte_off),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_misalign(wb_misalign), .retire_count(retire_count)
   );

   wb_select_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
      .in_read_data(in_read_data), .in_link(in_link), .in_imm(in_imm),
      .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
      .in_byte_off(in_byte_off),
      .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd), .wb_data(s_data),
      .wb_misalign(s_misalign), .retire_count(s_count)
   );

   // Writeback value from the source rules, using shifts and modulo on the raw word.
   function automatic logic [31:0] model_value(input logic [1:0] sel, input logic [31:0] alu,
         input logic [31:0] rdata, input logic [31:0] link, input logic [31:0] imm,
         input logic [1:0] size, input logic uns, input logic [1:0] off);
      logic [31:0] lane;
      case (sel)
         2'd0: return alu;
         2'd2: return link;
         2'd3: return imm;
         default: begin
`ifdef WB_LOAD_SUBWORD_EN
            if (size == 2'd0) begin
               lane = (rdata >> (8 * int'(off))) % 256;
               if (!uns && lane >= 128) lane = lane + 32'hFFFF_FF00;
               return lane;
            end else if (size == 2'd1) begin
               lane = (rdata >> (16 * (int'(off) / 2))) % 65536;
               if (!uns && lane >= 32768) lane = lane + 32'hFFFF_0000;
               return lane;
            end
            return rdata;
`else
            lane = rdata;
            if (size == 2'd0 && uns && off == 2'd0) lane = rdata;
            return lane;
`endif
         end
      endcase
   endfunction

   function automatic logic model_misalign(input logic [1:0] sel, input logic [1:0] size,
         input logic [1:0] off);
`ifdef WB_LOAD_SUBWORD_EN
      if (sel != 2'd1) return 1'b0;
      if (size == 2'd1) return (int'(off) % 2) == 1;
      if (size >= 2'd2) return off != 2'd0;
      return 1'b0;
`else
      return (sel == 2'd1) && (size == 2'd3) && (off == 2'd3) && 1'b0;
`endif
   endfunction

   logic        exp_valid, exp_we, exp_mis, exp_known;
   logic [4:0]  exp_rd;
   logic [31:0] exp_data;
   logic [31:0] exp_count;

   // Reference state: what the stage must hold after each edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_valid <= 1'b0; exp_we <= 1'b0; exp_mis <= 1'b0;
         exp_rd <= '0; exp_data <= '0; exp_known <= 1'b1; exp_count <= '0;
      end else if (flush) begin
         exp_valid <= 1'b0; exp_we <= 1'b0; exp_mis <= 1'b0;
      end else if (!stall) begin
         exp_valid <= in_valid;
         exp_mis   <= in_valid && model_misalign(in_wb_sel, in_mem_size, in_byte_off);
         exp_we    <= in_valid && in_reg_write && (in_rd != 0) &&
                      !model_misalign(in_wb_sel, in_mem_size, in_byte_off);
         exp_rd    <= in_rd;
         exp_data  <= model_value(in_wb_sel, in_alu_result, in_read_data, in_link, in_imm,
                                  in_mem_size, in_mem_unsigned, in_byte_off);
         exp_known <= !model_misalign(in_wb_sel, in_mem_size, in_byte_off);
         if (in_valid && in_reg_write && (in_rd != 0) &&
             !model_misalign(in_wb_sel, in_mem_size, in_byte_off))
            exp_count <= exp_count + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("m_valid", 32'(wb_valid), 32'(exp_valid));
      checkOutput("m_we", 32'(wb_we), 32'(exp_we));
      checkOutput("m_rd", 32'(wb_rd), 32'(exp_rd));
      if (exp_known) checkOutput("m_data", wb_data, exp_data);
      checkOutput("m_misalign", 32'(wb_misalign), 32'(exp_mis));
      checkOutput("m_count", retire_count, exp_count);
      checkOutput("m_count4", 32'(s_count), exp_count % 16);
   end

   task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] rd,
         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rdata,
         input logic [31:0] link, input logic [31:0] imm, input logic [1:0] size,
         input logic uns, input logic [1:0] off);
      in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
      in_alu_result = alu; in_read_data = rdata; in_link = link; in_imm = imm;
      in_mem_size = size; in_mem_unsigned = uns; in_byte_off = off;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [1:0]  sw_size [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
   logic        sw_uns  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [1:0]  sw_off  [4] = '{2'd1, 2'd3, 2'd2, 2'd2};
`ifdef WB_LOAD_SUBWORD_EN
   logic [31:0] sw_exp  [4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF};
`else
   logic [31:0] sw_exp  [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      checkOutput("reset_valid", 32'(wb_valid), 32'd0);
      checkOutput("reset_count", retire_count, 32'd0);
      rst_n = 1'b1;

      // Build non-zero state, then reset asynchronously in the middle of a stall.
      applyStimulus(1, 1, 5, 0, 32'h1111, 0, 0, 0, 0, 0, 0); step();
      applyStimulus(1, 1, 6, 0, 32'h2222, 0, 0, 0, 0, 0, 0); step();
      checkOutput("pre_reset_count", retire_count, 32'd2);
      stall = 1'b1; step();
      @(posedge clk); #2 rst_n = 1'b0; #1;
      checkOutput("async_valid", 32'(wb_valid), 32'd0);
      checkOutput("async_we", 32'(wb_we), 32'd0);
      checkOutput("async_rd", 32'(wb_rd), 32'd0);
      checkOutput("async_data", wb_data, 32'd0);
      checkOutput("async_count", retire_count, 32'd0);
      @(negedge clk);
      stall = 1'b0; rst_n = 1'b1;
      applyStimulus(1, 1, 8, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0); step();
      checkOutput("first_we", 32'(wb_we), 32'd1);
      checkOutput("first_rd", 32'(wb_rd), 32'd8);
      checkOutput("first_data", wb_data, 32'h0000_1234);
      checkOutput("first_count", retire_count, 32'd1);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 9, 1, 0, 32'h80FF_7F01, 0, 0, sw_size[i], sw_uns[i], sw_off[i]);
         step();
         checkOutput($sformatf("subword_%0d", i), wb_data, sw_exp[i]);
      end

      applyStimulus(1, 1, 9, 1, 0, 32'h80FF_7F01, 0, 0, 2'd1, 1'b0, 2'd1); step();
      checkOutput("mis_flag", 32'(wb_misalign), 32'(1 - MIS_EXTRA));
      checkOutput("mis_we", 32'(wb_we), 32'(MIS_EXTRA));
      checkOutput("mis_count", retire_count, 32'(5 + MIS_EXTRA));
      if (MIS_EXTRA == 1) checkOutput("mis_off_data", wb_data, 32'h80FF_7F01);
      applyStimulus(1, 1, 10, 0, 32'h0000_000A, 0, 0, 0, 0, 0, 0); step();
      checkOutput("mis_one_cycle", 32'(wb_misalign), 32'd0);

      // Inputs keep changing while stalled; the captured r10 write must stay put.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 11, 0, 32'hBEEF_0000 + i, 0, 0, 0, 0, 0, 0); step();
         checkOutput("stall_rd", 32'(wb_rd), 32'd10);
         checkOutput("stall_data", wb_data, 32'h0000_000A);
         checkOutput("stall_count", retire_count, 32'(6 + MIS_EXTRA));
      end
      flush = 1'b1; step();
      checkOutput("flush_valid", 32'(wb_valid), 32'd0);
      checkOutput("flush_we", 32'(wb_we), 32'd0);
      checkOutput("flush_rd_hold", 32'(wb_rd), 32'd10);
      stall = 1'b0; flush = 1'b0;

      applyStimulus(1, 1, 31, 2, 32'h1, 32'h2, 32'h0040_0008, 32'h3, 0, 0, 0); step();
      checkOutput("link_data", wb_data, 32'h0040_0008);
      applyStimulus(1, 1, 12, 3, 32'h1, 32'h2, 32'h3, 32'hABCD_0000, 0, 0, 0); step();
      checkOutput("imm_data", wb_data, 32'hABCD_0000);
      applyStimulus(1, 1, 0, 0, 32'h5555, 0, 0, 0, 0, 0, 0); step();
      checkOutput("zero_we", 32'(wb_we), 32'd0);
      checkOutput("zero_count", retire_count, 32'(8 + MIS_EXTRA));
      applyStimulus(0, 1, 13, 0, 32'h7777, 0, 0, 0, 0, 0, 0); step();
      checkOutput("invalid_we", 32'(wb_we), 32'd0);

      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 1, 5'(1 + (i % 31)), 0, 32'(i), 0, 0, 0, 0, 0, 0); step();
      end
      checkOutput("wrap_count4", 32'(s_count), 32'd1);
      checkOutput("wrap_count32", retire_count, 32'd17);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
